// File: rtl/bs_pkg.sv
// Shared constants, bus FSM state type and the packet-ID slice helper for the
// bus generator/arbiter.
package bs_pkg;
    localparam int ID_W    = 8;
    localparam int PKT_MAX = 1024;

    typedef enum logic [1:0] {IDLE, POP, DELIVER} bus_state_t;

    // Destination ID is the top ID_W bits of a packet of width sz.
    function automatic logic [ID_W-1:0] pkt_id(input logic [PKT_MAX-1:0] pkt, input int sz);
        return pkt[sz-1 -: ID_W];
    endfunction
endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin picker: first set request searching upward (with wrap) from
// the slot after the last grant. Purely combinational.
module bus_rr_arbiter #(
    parameter int N = 4,
    localparam int LG_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [LG_W-1:0] last_i,
    output logic [N-1:0]    gnt_o,
    output logic            vld_o
);
    always_comb begin
        int idx;
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(last_i) + i;
            if (idx >= N) idx = idx - N;
            if (!vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                vld_o      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus generator/arbiter: per bus, grant one pending source round-robin,
// pop its head packet and push it to the decoded destination(s).
// Broadcast fan-out is enabled by defining BS_BROADCAST_EN.
module bus_generator_arbiter
    import bs_pkg::*;
#(
    parameter int          bits      = 1,
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [bits-1:0][drvrs-1:0]             pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]             pop,
    output logic [bits-1:0][drvrs-1:0]             push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);
    localparam int LG_W = $clog2(drvrs);

    for (genvar b = 0; b < bits; b++) begin : g_bus
        bus_state_t       state_q, state_d;
        logic [LG_W-1:0]  src_q, src_d, last_q, last_d, gnt_idx;
        logic [pckg_sz-1:0] pkt_q, pkt_d;
        logic [drvrs-1:0] gnt, pop_b, push_b;
        logic             gnt_vld;
        logic [ID_W-1:0]  id;

        bus_rr_arbiter #(.N(drvrs)) u_arb (
            .req_i  (pndng[b]),
            .last_i (last_q),
            .gnt_o  (gnt),
            .vld_o  (gnt_vld)
        );

        always_comb begin
            gnt_idx = '0;
            for (int k = 0; k < drvrs; k++)
                if (gnt[k]) gnt_idx = LG_W'(k);
        end

        assign id = pkt_id({{(PKT_MAX-pckg_sz){1'b0}}, pkt_q}, pckg_sz);

        always_comb begin
            state_d = state_q;
            src_d   = src_q;
            last_d  = last_q;
            pkt_d   = pkt_q;
            pop_b   = '0;
            push_b  = '0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        src_d   = gnt_idx;
                        state_d = POP;
                    end
                end
                POP: begin
                    pop_b[src_q] = 1'b1;
                    pkt_d        = D_pop[b][src_q];
                    state_d      = DELIVER;
                end
                DELIVER: begin
                    // Broadcast takes priority; without the feature it is just dropped.
                    if (id == broadcast) begin
`ifdef BS_BROADCAST_EN
                        for (int k = 0; k < drvrs; k++)
                            if (LG_W'(k) != src_q) push_b[k] = 1'b1;
`endif
                    end else begin
                        for (int k = 0; k < drvrs; k++)
                            if (id == ID_W'(k)) push_b[k] = 1'b1;
                    end
                    last_d  = src_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                src_q   <= '0;
                last_q  <= LG_W'(drvrs-1);
                pkt_q   <= '0;
            end else begin
                state_q <= state_d;
                src_q   <= src_d;
                last_q  <= last_d;
                pkt_q   <= pkt_d;
            end
        end

        assign pop[b]    = pop_b;
        assign push[b]   = push_b;
        assign D_push[b] = {drvrs{pkt_q}};
    end
endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Randomized + directed bench for bus_generator_arbiter against a
// transaction-level reference model (source FIFOs held as queues).
module tb_bus_generator_arbiter;
    localparam int DRV = 4;
    localparam int PS  = 16;

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic [0:0][DRV-1:0]           pndng = '0;
    logic [0:0][DRV-1:0][PS-1:0]   D_pop = '0;
    logic [0:0][DRV-1:0]           pop, push;
    logic [0:0][DRV-1:0][PS-1:0]   D_push;

    bus_generator_arbiter #(.bits(1), .drvrs(DRV), .pckg_sz(PS), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc_n = 0;
    logic [PS-1:0] fifo [DRV][$];

    // reference-model state: what the current cycle must show
    logic [DRV-1:0] e_pop = '0, e_push = '0;
    logic [PS-1:0]  e_dpush = '0;
    int             e_src = 0, m_last = DRV-1;
    bit             m_del = 0;

    logic [DRV-1:0] seen_push;
    int             obs_pops[$], obs_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DRV-1:0] dmask(input logic [PS-1:0] p, input int src);
        int id = int'(p[PS-1 -: 8]);
        if (id == 255) begin
`ifdef BS_BROADCAST_EN
            return ~(DRV'(1) << src);
`else
            return '0;
`endif
        end
        if (id < DRV) return DRV'(1) << id;
        return '0;
    endfunction

    function automatic int rr_pick();
        for (int i = 1; i <= DRV; i++) begin
            int c = (m_last + i) % DRV;
            if (pndng[0][c]) return c;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < DRV; k++) begin
            pndng[0][k] = fifo[k].size() > 0;
            D_pop[0][k] = (fifo[k].size() > 0) ? fifo[k][0] : '0;
        end
    endtask

    task automatic model_reset();
        e_pop = '0; e_push = '0; e_dpush = '0; e_src = 0; m_last = DRV-1; m_del = 0;
    endtask

    task automatic cyc();
        logic [DRV-1:0] n_pop, n_push;
        logic [PS-1:0]  n_dpush;
        int             n_src, p;
        bit             n_del;
        @(negedge clk);
        chk("pop", 64'(pop), 64'(e_pop));
        chk("push", 64'(push), 64'(e_push));
        chk("dpush", 64'(D_push), 64'({DRV{e_dpush}}));
        seen_push = seen_push | push[0];
        for (int k = 0; k < DRV; k++)
            if (pop[0][k]) begin obs_pops.push_back(k); obs_cyc.push_back(cyc_n); end
        n_pop = '0; n_push = '0; n_dpush = e_dpush; n_src = e_src; n_del = 0;
        if (!reset) begin
            n_dpush = '0; n_src = 0; m_last = DRV-1;
        end else if (e_pop != 0) begin
            n_dpush = fifo[e_src][0];
            n_push  = dmask(n_dpush, e_src);
            n_del   = 1;
            m_last  = e_src;
            void'(fifo[e_src].pop_front());
        end else if (!m_del) begin
            p = rr_pick();
            if (p >= 0) begin n_pop = DRV'(1) << p; n_src = p; end
        end
        @(posedge clk); #1;
        cyc_n++;
        drive();
        e_pop = n_pop; e_push = n_push; e_dpush = n_dpush; e_src = n_src; m_del = n_del;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) cyc();
        reset = 1'b1;
    endtask

    initial begin
        bit hit;
        // reset held with traffic pending
        fifo[0].push_back(16'h0100);
        fifo[2].push_back(16'h0122);
        drive();
        repeat (3) cyc();
        reset = 1'b1;
        obs_pops.delete();
        repeat (8) cyc();
        chk("first_grant", 64'(obs_pops.size() > 0 ? obs_pops[0] : -1), 64'(0));

        // unicast 1 -> 3
        fifo[1].push_back(16'h0312); drive();
        seen_push = '0;
        repeat (6) cyc();
        chk("uni_push", 64'(seen_push), 64'(4'b1000));

        // broadcast from driver 2
        fifo[2].push_back(16'hFFAB); drive();
        seen_push = '0;
        repeat (6) cyc();
`ifdef BS_BROADCAST_EN
        chk("bcast_push", 64'(seen_push), 64'(4'b1011));
`else
        chk("bcast_push", 64'(seen_push), 64'(4'b0000));
`endif

        // round robin from a fresh reset
        do_reset();
        for (int k = 0; k < DRV; k++)
            repeat (2) fifo[k].push_back({8'h00, 8'($urandom)});
        drive();
        obs_pops.delete(); obs_cyc.delete();
        repeat (30) cyc();
        chk("rr_count", 64'(obs_pops.size()), 64'(8));
        for (int i = 0; i < 5; i++)
            chk("rr_order", 64'(obs_pops.size() > i ? obs_pops[i] : -1), 64'(i % DRV));
        chk("rr_spacing", 64'(obs_cyc.size() > 1 ? obs_cyc[1] - obs_cyc[0] : -1), 64'(3));

        // invalid destination
        fifo[3].push_back(16'h07AA); drive();
        seen_push = '0; obs_pops.delete();
        repeat (6) cyc();
        chk("inv_push", 64'(seen_push), 64'(0));
        chk("inv_pop", 64'(obs_pops.size()), 64'(1));

        // reset asserted during DELIVER
        fifo[1].push_back(16'h0312); drive();
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cyc();
            if (m_del) begin
                hit = 1;
                #1 reset = 1'b0;
                #1;
                chk("rstmid_push", 64'(push), 64'(0));
                chk("rstmid_dpush", 64'(D_push), 64'(0));
                model_reset();
            end
        end
        chk("rstmid_hit", 64'(hit), 64'(1));
        repeat (2) cyc();
        reset = 1'b1;
        seen_push = '0;
        repeat (6) cyc();
        chk("rstmid_nodeliver", 64'(seen_push), 64'(0));

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                int s = $urandom_range(0, DRV-1);
                int r = $urandom_range(0, 9);
                logic [7:0] id;
                if (r < 6)      id = 8'(r % DRV);
                else if (r < 8) id = 8'hFF;
                else            id = 8'($urandom_range(4, 254));
                if (fifo[s].size() < 4) fifo[s].push_back({id, 8'($urandom)});
                drive();
            end
            cyc();
        end
        repeat (60) cyc();
        for (int k = 0; k < DRV; k++)
            chk("drained", 64'(fifo[k].size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
